// File: rtl/hazard_scoreboard_if.sv
// Purpose: bundles the ID/EX/MEM/WB decode fields and hazard-control outputs of the scoreboard.
// Latency: wires only; no storage.
// Backpressure: stall and flush lines travel back to the fetch/decode stages through this bundle.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4
);
  // ID stage
  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_use_rs_i;
  logic                  id_use_rt_i;
  logic                  id_reg_write_i;
  logic                  id_is_fp_i;
  logic                  id_is_stop_i;
  // EX stage
  logic [REG_ADDR_W-1:0] ex_rs_i;
  logic [REG_ADDR_W-1:0] ex_rt_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  ex_reg_write_i;
  logic                  ex_is_load_i;
  logic                  branch_taken_i;
  // MEM / WB stages
  logic [REG_ADDR_W-1:0] mem_rd_i;
  logic [REG_ADDR_W-1:0] mem_rt_i;
  logic                  mem_reg_write_i;
  logic                  mem_is_store_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic                  wb_reg_write_i;
  // Control outputs
  logic [1:0]            alu_src1_o;
  logic [1:0]            alu_src2_o;
  logic                  mem_src_o;
  logic                  pc_stall_o;
  logic                  ifid_stall_o;
  logic                  flush_ifid_o;
  logic                  flush_idex_o;
  logic                  fp_busy_o;
  logic                  halted_o;

  // Pipeline side: drives decode fields, receives control.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_use_rs_i, id_use_rt_i,
           id_reg_write_i, id_is_fp_i, id_is_stop_i,
           ex_rs_i, ex_rt_i, ex_rd_i, ex_reg_write_i, ex_is_load_i, branch_taken_i,
           mem_rd_i, mem_rt_i, mem_reg_write_i, mem_is_store_i, wb_rd_i, wb_reg_write_i,
    input  alu_src1_o, alu_src2_o, mem_src_o, pc_stall_o, ifid_stall_o,
           flush_ifid_o, flush_idex_o, fp_busy_o, halted_o
  );

  // Scoreboard side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_use_rs_i, id_use_rt_i,
           id_reg_write_i, id_is_fp_i, id_is_stop_i,
           ex_rs_i, ex_rt_i, ex_rd_i, ex_reg_write_i, ex_is_load_i, branch_taken_i,
           mem_rd_i, mem_rt_i, mem_reg_write_i, mem_is_store_i, wb_rd_i, wb_reg_write_i,
    output alu_src1_o, alu_src2_o, mem_src_o, pc_stall_o, ifid_stall_o,
           flush_ifid_o, flush_idex_o, fp_busy_o, halted_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: forwarding select, load-use / FP scoreboard stalls, branch flush and STOP halt sequencing.
// Latency: forwarding and stalls are combinational; busy counters, fp_busy_o and halt state update next edge.
// Backpressure: pc/ifid stall freezes fetch+decode while a bubble is injected into ID/EX; branch overrides stalls.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 16,
  parameter int REG_ADDR_W   = 4,
  parameter int FP_LAT       = 3,
  parameter int FP_PIPELINED = 0,
  parameter int ZERO_REG_EN  = 1,
  parameter int DRAIN_CYC    = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_scoreboard_if.slave bus
);
  localparam int BW = $clog2(FP_LAT + 1);
  localparam int DW = $clog2(DRAIN_CYC + 2);

  typedef logic [REG_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t              state;
  logic [DW-1:0]       drain_cnt;
  logic                halted_q;
  logic                fp_busy_q;
  logic [BW-1:0]       busy     [NUM_REGS];
  logic [BW-1:0]       busy_nxt [NUM_REGS];
  logic                any_busy_nxt;
  logic [NUM_REGS-1:0] busy_raw;  // counter nonzero, any register
  logic [NUM_REGS-1:0] busy_src;  // same, but r0 masked when it is hardwired
  logic                load_use, sb_stall, fp_stall, hz_stall;
  logic                issue_ok, issue_fp, issue_stop;

  // Register match; r0 never matches when it is the hardwired zero register.
  function automatic logic hit(input addr_t a, input addr_t b);
    return (a == b) && !((ZERO_REG_EN != 0) && (a == '0));
  endfunction

  // Per-register flag lookup; addresses beyond NUM_REGS are never busy.
  function automatic logic lookup(input logic [NUM_REGS-1:0] v, input addr_t a);
    return (int'(a) < NUM_REGS) ? v[a] : 1'b0;
  endfunction

  // Operand forwarding: MEM result beats WB result; store data forwarded from WB.
  always_comb begin
    bus.alu_src1_o = 2'b00;
    bus.alu_src2_o = 2'b00;
    if (bus.mem_reg_write_i && hit(bus.mem_rd_i, bus.ex_rs_i))     bus.alu_src1_o = 2'b10;
    else if (bus.wb_reg_write_i && hit(bus.wb_rd_i, bus.ex_rs_i))  bus.alu_src1_o = 2'b01;
    if (bus.mem_reg_write_i && hit(bus.mem_rd_i, bus.ex_rt_i))     bus.alu_src2_o = 2'b10;
    else if (bus.wb_reg_write_i && hit(bus.wb_rd_i, bus.ex_rt_i))  bus.alu_src2_o = 2'b01;
    bus.mem_src_o = bus.mem_is_store_i && bus.wb_reg_write_i && hit(bus.wb_rd_i, bus.mem_rt_i);
  end

  // Busy flags derived from the per-register FP result counters.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_raw[r] = (busy[r] != '0);
      busy_src[r] = busy_raw[r] && !((ZERO_REG_EN != 0) && (r == 0));
    end
  end

  // Hazard detection and issue qualification; stalls only matter while running.
  always_comb begin
    load_use = bus.ex_is_load_i && bus.ex_reg_write_i &&
               ((bus.id_use_rs_i && hit(bus.ex_rd_i, bus.id_rs_i)) ||
                (bus.id_use_rt_i && hit(bus.ex_rd_i, bus.id_rt_i)));
    sb_stall = bus.id_valid_i &&
               ((bus.id_use_rs_i && lookup(busy_src, bus.id_rs_i)) ||
                (bus.id_use_rt_i && lookup(busy_src, bus.id_rt_i)));
    if (FP_PIPELINED != 0) fp_stall = bus.id_is_fp_i && lookup(busy_raw, bus.id_rd_i);
    else                   fp_stall = bus.id_is_fp_i && (|busy_raw);
    hz_stall   = (state == RUN) && (load_use || sb_stall || fp_stall);
    issue_ok   = (state == RUN) && bus.id_valid_i && !hz_stall && !bus.branch_taken_i;
    issue_fp   = issue_ok && bus.id_is_fp_i && bus.id_reg_write_i;
    issue_stop = issue_ok && bus.id_is_stop_i;
  end

  // Next counter values: saturating decrement, reload on FP issue to that destination.
  always_comb begin
    any_busy_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_nxt[r] = (busy[r] != '0) ? busy[r] - BW'(1) : '0;
      if (issue_fp && (int'(bus.id_rd_i) == r)) busy_nxt[r] = BW'(FP_LAT);
      any_busy_nxt = any_busy_nxt | (busy_nxt[r] != '0);
    end
  end

  // Scoreboard state and registered fp_busy flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) busy[r] <= '0;
      fp_busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) busy[r] <= busy_nxt[r];
      fp_busy_q <= any_busy_nxt;
    end
  end

  // Halt sequencer: leave DRAIN once the counter reaches zero this cycle and no FP op remains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (issue_stop) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYC);
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
          if ((drain_cnt <= DW'(1)) && !fp_busy_q) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED:  halted_q <= 1'b1;
        default: state    <= RUN;
      endcase
    end
  end

  // Stall/flush outputs per state; a taken branch overrides every stall.
  always_comb begin
    bus.pc_stall_o   = 1'b0;
    bus.ifid_stall_o = 1'b0;
    bus.flush_ifid_o = 1'b0;
    bus.flush_idex_o = 1'b0;
    unique case (state)
      RUN: begin
        bus.pc_stall_o   = hz_stall;
        bus.ifid_stall_o = hz_stall;
        bus.flush_idex_o = hz_stall;
      end
      DRAIN: begin
        bus.pc_stall_o   = 1'b1;
        bus.ifid_stall_o = 1'b1;
        bus.flush_ifid_o = 1'b1;
      end
      HALTED: begin
        bus.pc_stall_o   = 1'b1;
        bus.ifid_stall_o = 1'b1;
        bus.flush_idex_o = 1'b1;
      end
      default: ;
    endcase
    if (bus.branch_taken_i) begin
      bus.pc_stall_o   = 1'b0;
      bus.ifid_stall_o = 1'b0;
      bus.flush_ifid_o = 1'b1;
      bus.flush_idex_o = 1'b1;
    end
  end

  assign bus.fp_busy_o = fp_busy_q;
  assign bus.halted_o  = halted_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: self-checking bench for hazard_scoreboard (forwarding, load-use, FP scoreboard, branch, halt).
// Latency: inputs driven on negedge, outputs sampled 2 time units later, before the next posedge.
// Backpressure: expected output records queued at drive time and popped when the outputs are sampled.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;

  hazard_scoreboard_if #(.REG_ADDR_W(4)) bus ();

  hazard_scoreboard #(
    .NUM_REGS(16), .REG_ADDR_W(4), .FP_LAT(3), .FP_PIPELINED(0),
    .ZERO_REG_EN(1), .DRAIN_CYC(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id_valid;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       use_rs, use_rt, reg_write, is_fp, is_stop;
    logic [3:0] ex_rs, ex_rt, ex_rd;
    logic       ex_we, ex_load, br;
    logic [3:0] mem_rd, mem_rt;
    logic       mem_we, mem_store;
    logic [3:0] wb_rd;
    logic       wb_we;
  } in_t;

  typedef struct packed {
    logic [1:0] a1, a2;
    logic       ms, ps, is, fi, fx, fb, h;
  } exp_t;

  typedef struct {
    in_t   v;
    exp_t  e;
    string n;
  } vec_t;

  vec_t  tbl[$];
  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic exp_t mk(input logic [1:0] a1, input logic [1:0] a2, input logic ms,
                              input logic ps, input logic is, input logic fi, input logic fx,
                              input logic fb, input logic h);
    exp_t e;
    e.a1 = a1; e.a2 = a2; e.ms = ms; e.ps = ps; e.is = is;
    e.fi = fi; e.fx = fx; e.fb = fb; e.h = h;
    return e;
  endfunction

  // Expected output shapes used repeatedly.
  function automatic exp_t e_idle(input logic fb);
    return mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fb, 1'b0);
  endfunction
  function automatic exp_t e_stall(input logic fb);
    return mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, fb, 1'b0);
  endfunction
  function automatic exp_t e_drain(input logic fb);
    return mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, fb, 1'b0);
  endfunction

  task automatic add(input in_t v, input exp_t e, input string n);
    vec_t t;
    t.v = v; t.e = e; t.n = n;
    tbl.push_back(t);
  endtask

  task automatic apply(input in_t v);
    bus.id_valid_i      = v.id_valid;
    bus.id_rs_i         = v.id_rs;
    bus.id_rt_i         = v.id_rt;
    bus.id_rd_i         = v.id_rd;
    bus.id_use_rs_i     = v.use_rs;
    bus.id_use_rt_i     = v.use_rt;
    bus.id_reg_write_i  = v.reg_write;
    bus.id_is_fp_i      = v.is_fp;
    bus.id_is_stop_i    = v.is_stop;
    bus.ex_rs_i         = v.ex_rs;
    bus.ex_rt_i         = v.ex_rt;
    bus.ex_rd_i         = v.ex_rd;
    bus.ex_reg_write_i  = v.ex_we;
    bus.ex_is_load_i    = v.ex_load;
    bus.branch_taken_i  = v.br;
    bus.mem_rd_i        = v.mem_rd;
    bus.mem_rt_i        = v.mem_rt;
    bus.mem_reg_write_i = v.mem_we;
    bus.mem_is_store_i  = v.mem_store;
    bus.wb_rd_i         = v.wb_rd;
    bus.wb_reg_write_i  = v.wb_we;
  endtask

  task automatic check_out();
    exp_t  e;
    exp_t  act;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    act = mk(bus.alu_src1_o, bus.alu_src2_o, bus.mem_src_o, bus.pc_stall_o, bus.ifid_stall_o,
             bus.flush_ifid_o, bus.flush_idex_o, bus.fp_busy_o, bus.halted_o);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got a1=%b a2=%b ms=%b pc=%b ifid=%b fl_ifid=%b fl_idex=%b fpb=%b halt=%b, expected a1=%b a2=%b ms=%b pc=%b ifid=%b fl_ifid=%b fl_idex=%b fpb=%b halt=%b",
               n, act.a1, act.a2, act.ms, act.ps, act.is, act.fi, act.fx, act.fb, act.h,
               e.a1, e.a2, e.ms, e.ps, e.is, e.fi, e.fx, e.fb, e.h);
    end
  endtask

  // One cycle: drive on negedge, queue the expectation, sample before the posedge.
  task automatic step(input in_t v, input exp_t e, input string n);
    @(negedge clk);
    apply(v);
    exp_q.push_back(e);
    name_q.push_back(n);
    #2;
    check_out();
  endtask

  task automatic do_reset();
    in_t z;
    z = '0;
    @(negedge clk);
    rst = 1'b1;
    apply(z);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  in_t v;
  in_t idle;

  initial begin
    idle = '0;
    rst  = 1'b1;
    apply(idle);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---------------- table of single-cycle vectors ----------------
    v = idle;                                                   add(v, e_idle(1'b0), "reset_idle");
    v = idle; v.ex_rs = 3; v.ex_rt = 7; v.mem_rd = 3; v.mem_we = 1; v.wb_rd = 3; v.wb_we = 1;
    add(v, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0), "fwd1_mem_prio");
    v.mem_we = 0;                                               add(v, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0), "fwd1_wb");
    v = idle; v.mem_we = 1; v.wb_we = 1;                        add(v, e_idle(1'b0), "fwd_r0_masked");
    v = idle; v.ex_rs = 5; v.ex_rt = 5; v.mem_rd = 5; v.mem_we = 1; v.wb_rd = 5; v.wb_we = 1;
    add(v, mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0), "fwd_both_mem");
    v = idle; v.ex_rs = 1; v.ex_rt = 9; v.mem_rd = 9; v.wb_rd = 9; v.wb_we = 1;
    add(v, mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0), "fwd2_wb");
    v = idle; v.ex_rs = 2; v.mem_rd = 2; v.mem_we = 1; v.wb_rd = 1; v.wb_we = 1;
    add(v, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0), "fwd1_mem_only");
    v = idle; v.mem_store = 1; v.mem_rt = 6; v.wb_rd = 6; v.wb_we = 1;
    add(v, mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0), "store_fwd");
    v.mem_store = 0;                                            add(v, e_idle(1'b0), "store_fwd_nostore");
    v = idle; v.mem_store = 1; v.wb_we = 1;                     add(v, e_idle(1'b0), "store_fwd_r0");
    v = idle; v.id_valid = 1; v.id_rs = 5; v.use_rs = 1; v.ex_rd = 5; v.ex_we = 1; v.ex_load = 1;
    add(v, e_stall(1'b0), "loaduse_rs");
    v = idle; v.id_valid = 1; v.id_rt = 5; v.ex_rd = 5; v.ex_we = 1; v.ex_load = 1;
    add(v, e_idle(1'b0), "loaduse_rt_unused");
    v.use_rt = 1;                                               add(v, e_stall(1'b0), "loaduse_rt");
    v = idle; v.id_valid = 1; v.use_rs = 1; v.ex_we = 1; v.ex_load = 1;
    add(v, e_idle(1'b0), "loaduse_r0");
    v = idle; v.id_valid = 1; v.id_rs = 5; v.use_rs = 1; v.ex_rd = 5; v.ex_load = 1;
    add(v, e_idle(1'b0), "loaduse_nowrite");
    v = idle; v.id_valid = 1; v.id_rs = 5; v.use_rs = 1; v.is_stop = 1;
    v.ex_rd = 5; v.ex_we = 1; v.ex_load = 1; v.br = 1;
    add(v, mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0), "branch_wins");
    v = idle;                                                   add(v, e_idle(1'b0), "branch_no_drain");
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 4; v.br = 1;
    add(v, mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0), "branch_fp_blocked");
    v = idle;                                                   add(v, e_idle(1'b0), "branch_no_busy");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i].v, tbl[i].e, tbl[i].n);

    // ---------------- load-use lasts exactly one cycle ----------------
    v = idle; v.id_valid = 1; v.id_rs = 5; v.use_rs = 1; v.ex_rd = 5; v.ex_we = 1; v.ex_load = 1;
    step(v, e_stall(1'b0), "lw_stall_cycle");
    v = idle; v.id_valid = 1; v.id_rs = 5; v.use_rs = 1; v.ex_rd = 5; v.ex_we = 1;
    step(v, e_idle(1'b0), "lw_stall_released");

    // ---------------- FP RAW: MULTF r4 then consumer of r4 ----------------
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 4;
    step(v, e_idle(1'b0), "multf_issue");
    v = idle; v.id_valid = 1; v.id_rs = 4; v.use_rs = 1;
    for (int i = 0; i < 3; i++) step(v, e_stall(1'b1), $sformatf("raw_stall_%0d", i));
    step(v, e_idle(1'b0), "raw_release");

    // ---------------- FP structural: ADDF r6 behind MULTF r4 ----------------
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 4;
    step(v, e_idle(1'b0), "multf_issue2");
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 6;
    for (int i = 0; i < 3; i++) step(v, e_stall(1'b1), $sformatf("struct_stall_%0d", i));
    step(v, e_idle(1'b0), "addf_issue");
    for (int i = 0; i < 3; i++) step(idle, e_idle(1'b1), $sformatf("addf_busy_%0d", i));
    step(idle, e_idle(1'b0), "addf_done");

    // ---------------- STOP with busy[2]=2: drain 3, halt on 4th ----------------
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 2;
    step(v, e_idle(1'b0), "addf_r2_issue");
    step(idle, e_idle(1'b1), "r2_busy3");
    v = idle; v.id_valid = 1; v.is_stop = 1;
    step(v, e_idle(1'b1), "stop_issue");
    step(idle, e_drain(1'b1), "drain_0");
    step(idle, e_drain(1'b0), "drain_1");
    step(idle, e_drain(1'b0), "drain_2");
    step(idle, mk(2'b00, 2'b00, 0, 1, 1, 0, 1, 0, 1), "halted_0");
    step(idle, mk(2'b00, 2'b00, 0, 1, 1, 0, 1, 0, 1), "halted_1");
    v = idle; v.ex_rs = 3; v.mem_rd = 3; v.mem_we = 1;
    step(v, mk(2'b10, 2'b00, 0, 1, 1, 0, 1, 0, 1), "halted_fwd_live");
    do_reset();
    step(idle, e_idle(1'b0), "post_halt_reset");

    // ---------------- reset mid-FP discards busy state ----------------
    v = idle; v.id_valid = 1; v.is_fp = 1; v.reg_write = 1; v.id_rd = 4;
    step(v, e_idle(1'b0), "fp_before_reset");
    do_reset();
    v = idle; v.id_valid = 1; v.id_rs = 4; v.use_rs = 1;
    step(v, e_idle(1'b0), "fp_reset_cleared");

    // ---------------- reset mid-DRAIN returns to RUN ----------------
    v = idle; v.id_valid = 1; v.is_stop = 1;
    step(v, e_idle(1'b0), "stop_before_reset");
    step(idle, e_drain(1'b0), "drain_before_reset");
    do_reset();
    step(idle, e_idle(1'b0), "drain_reset_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, architectural register count.
REQ-002 SHALL have parameter REG_ADDR_W, default 4, register address width; NUM_REGS <= 2**REG_ADDR_W.
REQ-003 SHALL have parameter FP_LAT, default 3, cycles from ADDF/MULTF issue until result reaches WB; range 1..7.
REQ-004 SHALL have parameter FP_PIPELINED, default 0: 0 = one FP op in flight; 1 = back-to-back FP issue.
REQ-005 SHALL have parameter ZERO_REG_EN, default 1: 1 = register 0 never forwarded, never a hazard source.
REQ-006 SHALL have parameter DRAIN_CYC, default 3, pipeline drain cycles after STOP.
REQ-007 SHALL have ports: clk_i in 1, system clock; rst_i in 1, synchronous active-high reset; the block has one clock.
REQ-008 SHALL have ports: id_valid_i in 1; id_rs_i, id_rt_i, id_rd_i in REG_ADDR_W; id_use_rs_i, id_use_rt_i, id_reg_write_i, id_is_fp_i, id_is_stop_i in 1 (ID-stage decode).
REQ-009 SHALL have ports: ex_rs_i, ex_rt_i, ex_rd_i in REG_ADDR_W; ex_reg_write_i, ex_is_load_i, branch_taken_i in 1 (EX stage; JMPZ resolves in EX).
REQ-010 SHALL have ports: mem_rd_i, mem_rt_i in REG_ADDR_W; mem_reg_write_i, mem_is_store_i in 1; wb_rd_i in REG_ADDR_W; wb_reg_write_i in 1.
REQ-011 SHALL have outputs: alu_src1_o, alu_src2_o out 2; mem_src_o, pc_stall_o, ifid_stall_o, flush_ifid_o, flush_idex_o, fp_busy_o, halted_o out 1.

Function
REQ-012 Forwarding (combinational): alu_src1_o = 2'b10 if mem_reg_write_i and mem_rd_i==ex_rs_i; else 2'b01 if wb_reg_write_i and wb_rd_i==ex_rs_i; else 2'b00. MEM has priority over WB.
REQ-013 alu_src2_o SHALL follow REQ-012 using ex_rt_i.
REQ-014 mem_src_o SHALL be 1 when mem_is_store_i, wb_reg_write_i and wb_rd_i==mem_rt_i (WB->MEM store-data forward).
REQ-015 With ZERO_REG_EN=1, any match on register 0 SHALL be treated as no match (REQ-012..014, REQ-016, REQ-018).
REQ-016 Load-use: ex_is_load_i and ex_reg_write_i and ID source used (id_use_*) equal to ex_rd_i SHALL assert pc_stall_o, ifid_stall_o, flush_idex_o for that cycle.
REQ-017 Scoreboard: per-register down-counter busy[r], width $clog2(FP_LAT+1); decrements by 1 each cycle, saturates at 0.
REQ-018 Scoreboard stall: id_valid_i and a used ID source r with busy[r]!=0 SHALL assert the REQ-016 stall set.
REQ-019 FP structural stall: id_is_fp_i with FP_PIPELINED=0 and any busy[r]!=0, or FP_PIPELINED=1 and busy[id_rd_i]!=0 (WAW), SHALL assert the stall set.
REQ-020 FP issue: id_valid_i, id_is_fp_i, id_reg_write_i, no stall, no branch_taken_i SHALL load busy[id_rd_i]=FP_LAT next cycle.
REQ-021 fp_busy_o SHALL be the OR of all busy counters (registered).
REQ-022 Branch: branch_taken_i SHALL assert flush_ifid_o and flush_idex_o, deassert pc_stall_o/ifid_stall_o, and block issue (REQ-020, REQ-023); branch wins over every stall.
REQ-023 Halt FSM states RUN, DRAIN, HALTED. RUN->DRAIN when id_valid_i, id_is_stop_i, no stall, no branch_taken_i; drain counter loads DRAIN_CYC.
REQ-024 DRAIN: pc_stall_o, ifid_stall_o, flush_ifid_o asserted; counter decrements; DRAIN->HALTED when counter==0 and fp_busy_o==0 (waits for FP if needed).
REQ-025 HALTED: pc_stall_o, ifid_stall_o, flush_idex_o, halted_o = 1; exit only via rst_i.
REQ-026 Forwarding outputs SHALL remain live in all FSM states.

Reset
REQ-027 rst_i sampled high on clk_i edge SHALL clear all busy counters, drain counter, FSM to RUN, fp_busy_o=0, halted_o=0.
REQ-028 Reset mid-DRAIN or mid-FP SHALL discard pending state within one cycle; no stall output from scoreboard/FSM the cycle after.

Verification
REQ-029 MEM rd=3 write, WB rd=3 write, ex_rs=3 -> alu_src1_o=2'b10; drop MEM write -> 2'b01; rd=0 with ZERO_REG_EN=1 -> 2'b00.
REQ-030 LW to r5 in EX, ID uses r5 -> one cycle pc_stall_o=ifid_stall_o=flush_idex_o=1, then 0.
REQ-031 FP_LAT=3: MULTF r4 issued, next ID uses r4 -> stall exactly 3 cycles; FP_PIPELINED=0 second ADDF r6 also stalls 3 cycles.
REQ-032 branch_taken_i coincident with load-use and STOP in ID -> flushes asserted, stalls 0, FSM stays RUN, no busy load.
REQ-033 STOP with DRAIN_CYC=3, busy[2]=2 -> DRAIN 3 cycles, HALTED on 4th, halted_o stays 1; rst_i -> RUN, all outputs 0.
